mt_branch_resolve: RTL and testbench
====================================

Name: mt_branch_resolve

Overview:
- Execute-stage branch/jump resolver for the barrel-threaded RV32I core.
- Evaluates the branch condition and target of the instruction in EX and drives the registered redirect (pc_src_e, branch_tid_e, pc_target_e) into the fetch-stage per-thread PC file.
- Keeps a per-thread epoch bit. Fetch tags each instruction with that bit, and this block squashes stale wrong-path instructions when they reach EX.
- Fetch is predict-not-taken: only taken branches and jumps redirect.

Parameters:
- NUM_THREADS, 8, hardware thread count.
- BITS_THREADS, $clog2(NUM_THREADS), thread-id width.
- ADDRESS_WIDTH, 32, PC/target width.
- DATA_WIDTH, 32, register operand width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_e  in  1  instruction present in EX
- tid_e  in  BITS_THREADS  thread of EX instruction
- epoch_e  in  1  epoch tag captured at fetch
- br_type_e  in  4  NONE=0,BEQ,BNE,BLT,BGE,BLTU,BGEU,JAL,JALR=8; others treated as NONE
- pc_e  in  ADDRESS_WIDTH  PC of EX instruction
- imm_e  in  ADDRESS_WIDTH  sign-extended immediate
- rs1_e, rs2_e  in  DATA_WIDTH  forwarded operands
- fetch_tid  in  BITS_THREADS  thread being fetched this cycle
- fetch_epoch  out  1  epoch[fetch_tid], combinational
- kill_e  out  1  EX instruction is wrong-path; downstream suppresses writeback/memory
- pc_src_e  out  1  registered redirect valid
- branch_tid_e  out  BITS_THREADS  registered redirect thread
- pc_target_e  out  ADDRESS_WIDTH  registered redirect target

Behaviour:
- Reset state:
  - All epoch bits 0.
  - pc_src_e=0, branch_tid_e=0, pc_target_e=0.
  - Reset mid-operation drops any pending redirect.
- kill_e is combinational:
  - kill_e = valid_e && ((epoch_e != epoch[tid_e]) || (pc_src_e && branch_tid_e == tid_e)).
  - The second term covers the one-cycle window before the epoch flips. No correct-path instruction of a redirected thread can reach EX within one cycle of the redirect, so this term kills only wrong-path instructions.
- Taken condition (combinational; BLT/BGE signed, BLTU/BGEU unsigned):
  - BEQ: rs1==rs2. BNE: !=.
  - BLT: signed <. BGE: signed >=.
  - BLTU: unsigned <. BGEU: unsigned >=.
  - JAL, JALR: always taken.
- Target, modulo 2^ADDRESS_WIDTH (wraps silently):
  - Branches and JAL: pc_e+imm_e.
  - JALR: (rs1_e+imm_e) with bit 0 cleared.
  - Misaligned-target exceptions are out of scope.
- Redirect timing:
  - redirect = valid_e && !kill_e && taken.
  - At the next posedge: pc_src_e<=redirect, branch_tid_e<=tid_e, pc_target_e<=target. Latency is 1 cycle.
  - When redirect=0: pc_src_e<=0; branch_tid_e and pc_target_e hold.
- Epoch update:
  - On the posedge where pc_src_e==1, epoch[branch_tid_e] toggles.
  - This is the same edge at which the PC file loads pc_target_e.
  - A fetch issued while pc_src_e==1 therefore reads the old PC with the old epoch and is later killed. The next fetch gets the new PC with the new epoch.
- At most one redirect per cycle, since EX holds one instruction.
- Back-to-back redirects for different threads are independent, each toggling its own epoch.
- fetch_epoch reflects the register value only; no bypass of the pending toggle.
- NONE and killed instructions never change state.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- With the macro defined:
  - Extra ports stat_tid (in, BITS_THREADS), stat_branches (out, 32), stat_taken (out, 32).
  - Per-thread 32-bit counters, cleared on rst.
  - branches increments for each non-killed valid instruction with br_type_e != NONE.
  - taken increments when redirect=1.
  - Both counters saturate at 0xFFFFFFFF.
  - Reads are combinational, indexed by stat_tid.
- Without the macro: no ports, no counters. Core behaviour is identical either way.

Decomposition:
- Shared package holds:
  - br_type encodings (BR_NONE..BR_JALR), 4-bit width constant.
  - Default NUM_THREADS and ADDRESS_WIDTH constants.
- Natural sub-module: br_cond_eval (pure combinational compare of rs1/rs2 by br_type, output taken).
- Epoch array, redirect register and stats stay in mt_branch_resolve.

Test Plan:
1. rst, then BEQ tid=3, epoch_e=0, rs1=rs2=5, pc=0x100, imm=0x20 -> next cycle pc_src_e=1, branch_tid_e=3, pc_target_e=0x120; following cycle epoch[3]=1, pc_src_e=0.
2. BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU same operands -> not taken, pc_src_e stays 0.
3. JALR rs1=0x203, imm=0 -> pc_target_e=0x202. JAL pc=0xFFFFFFFC, imm=8 -> target 0x4 (wrap).
4. After redirect of tid 3, EX gets tid 3 with epoch_e=0 -> kill_e=1, no redirect even if taken. tid 3 in EX while pc_src_e=1 for tid 3 -> kill_e=1. tid 4 with epoch 0 -> kill_e=0.
5. Redirects for tid 1 then tid 2 on consecutive cycles -> two consecutive pc_src_e pulses; epoch[1] and epoch[2] both toggle; fetch_epoch for fetch_tid=1 reads 1 after toggle.
6. BRANCH_STATS_EN: 3 branches on tid 0, 2 taken, 1 killed branch -> stat_branches=3, stat_taken=2. Preload a counter to 0xFFFFFFFF, increment -> value holds.

Source files
------------

// File: rtl/mt_branch_resolve_pkg.sv
// rtl/mt_branch_resolve_pkg.sv - shared branch type encodings and default sizes for mt_branch_resolve
package mt_branch_resolve_pkg;

    localparam int BR_TYPE_W         = 4;
    localparam int DEF_NUM_THREADS   = 8;
    localparam int DEF_ADDRESS_WIDTH = 32;

    localparam logic [BR_TYPE_W-1:0] BR_NONE = 4'd0;
    localparam logic [BR_TYPE_W-1:0] BR_BEQ  = 4'd1;
    localparam logic [BR_TYPE_W-1:0] BR_BNE  = 4'd2;
    localparam logic [BR_TYPE_W-1:0] BR_BLT  = 4'd3;
    localparam logic [BR_TYPE_W-1:0] BR_BGE  = 4'd4;
    localparam logic [BR_TYPE_W-1:0] BR_BLTU = 4'd5;
    localparam logic [BR_TYPE_W-1:0] BR_BGEU = 4'd6;
    localparam logic [BR_TYPE_W-1:0] BR_JAL  = 4'd7;
    localparam logic [BR_TYPE_W-1:0] BR_JALR = 4'd8;

endpackage

// File: rtl/mt_branch_resolve_br_cond_eval.sv
// rtl/mt_branch_resolve_br_cond_eval.sv - combinational branch condition evaluation by br_type
module mt_branch_resolve_br_cond_eval
    import mt_branch_resolve_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [BR_TYPE_W-1:0]  br_type,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    output logic                  taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = (rs1 == rs2);
            BR_BNE:  taken = (rs1 != rs2);
            BR_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            BR_BLTU: taken = (rs1 <  rs2);
            BR_BGEU: taken = (rs1 >= rs2);
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mt_branch_resolve.sv
// rtl/mt_branch_resolve.sv - EX-stage branch resolver with per-thread epochs; BRANCH_STATS_EN adds per-thread counters
module mt_branch_resolve
    import mt_branch_resolve_pkg::*;
#(
    parameter int NUM_THREADS   = DEF_NUM_THREADS,
    parameter int BITS_THREADS  = $clog2(NUM_THREADS),
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_e,
    input  logic [BITS_THREADS-1:0]  tid_e,
    input  logic                     epoch_e,
    input  logic [BR_TYPE_W-1:0]     br_type_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_e,
    input  logic [ADDRESS_WIDTH-1:0] imm_e,
    input  logic [DATA_WIDTH-1:0]    rs1_e,
    input  logic [DATA_WIDTH-1:0]    rs2_e,
    input  logic [BITS_THREADS-1:0]  fetch_tid,
`ifdef BRANCH_STATS_EN
    input  logic [BITS_THREADS-1:0]  stat_tid,
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_taken,
`endif
    output logic                     fetch_epoch,
    output logic                     kill_e,
    output logic                     pc_src_e,
    output logic [BITS_THREADS-1:0]  branch_tid_e,
    output logic [ADDRESS_WIDTH-1:0] pc_target_e
);

    logic [NUM_THREADS-1:0]   epoch_q, epoch_d;
    logic                     pc_src_q, pc_src_d;
    logic [BITS_THREADS-1:0]  branch_tid_q, branch_tid_d;
    logic [ADDRESS_WIDTH-1:0] pc_target_q, pc_target_d;
    logic                     taken;
    logic                     redirect;
    logic [ADDRESS_WIDTH-1:0] jalr_sum;
    logic [ADDRESS_WIDTH-1:0] target;

    mt_branch_resolve_br_cond_eval #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_br_cond_eval (
        .br_type (br_type_e),
        .rs1     (rs1_e),
        .rs2     (rs2_e),
        .taken   (taken)
    );

    // The pending-redirect term kills the one wrong-path slot before the epoch flips.
    assign kill_e      = valid_e && ((epoch_e != epoch_q[tid_e]) ||
                                     (pc_src_q && (branch_tid_q == tid_e)));
    assign redirect    = valid_e && !kill_e && taken;
    assign fetch_epoch = epoch_q[fetch_tid];

    assign jalr_sum = rs1_e[ADDRESS_WIDTH-1:0] + imm_e;
    assign target   = (br_type_e == BR_JALR) ? {jalr_sum[ADDRESS_WIDTH-1:1], 1'b0}
                                             : (pc_e + imm_e);

    always_comb begin
        epoch_d = epoch_q;
        if (pc_src_q) begin
            epoch_d[branch_tid_q] = ~epoch_q[branch_tid_q];
        end
        pc_src_d     = redirect;
        branch_tid_d = redirect ? tid_e  : branch_tid_q;
        pc_target_d  = redirect ? target : pc_target_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            epoch_q      <= '0;
            pc_src_q     <= 1'b0;
            branch_tid_q <= '0;
            pc_target_q  <= '0;
        end else begin
            epoch_q      <= epoch_d;
            pc_src_q     <= pc_src_d;
            branch_tid_q <= branch_tid_d;
            pc_target_q  <= pc_target_d;
        end
    end

    assign pc_src_e     = pc_src_q;
    assign branch_tid_e = branch_tid_q;
    assign pc_target_e  = pc_target_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q [NUM_THREADS];
    logic [31:0] stat_br_d [NUM_THREADS];
    logic [31:0] stat_tk_q [NUM_THREADS];
    logic [31:0] stat_tk_d [NUM_THREADS];
    logic        counts_branch;

    assign counts_branch = valid_e && !kill_e &&
                           (br_type_e >= BR_BEQ) && (br_type_e <= BR_JALR);

    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            stat_br_d[i] = stat_br_q[i];
            stat_tk_d[i] = stat_tk_q[i];
        end
        if (counts_branch && (stat_br_q[tid_e] != 32'hFFFF_FFFF)) begin
            stat_br_d[tid_e] = stat_br_q[tid_e] + 32'd1;
        end
        if (redirect && (stat_tk_q[tid_e] != 32'hFFFF_FFFF)) begin
            stat_tk_d[tid_e] = stat_tk_q[tid_e] + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (rst) begin
                stat_br_q[i] <= '0;
                stat_tk_q[i] <= '0;
            end else begin
                stat_br_q[i] <= stat_br_d[i];
                stat_tk_q[i] <= stat_tk_d[i];
            end
        end
    end

    assign stat_branches = stat_br_q[stat_tid];
    assign stat_taken    = stat_tk_q[stat_tid];
`endif

endmodule

// File: tb/tb_mt_branch_resolve.sv
// tb/tb_mt_branch_resolve.sv - self-checking bench for mt_branch_resolve (table, directed sequences, random vs model)
module tb_mt_branch_resolve;
    import mt_branch_resolve_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_e = 1'b0;
    logic [2:0]  tid_e = '0;
    logic        epoch_e = 1'b0;
    logic [3:0]  br_type_e = '0;
    logic [31:0] pc_e = '0, imm_e = '0, rs1_e = '0, rs2_e = '0;
    logic [2:0]  fetch_tid = '0;
    logic        fetch_epoch, kill_e, pc_src_e;
    logic [2:0]  branch_tid_e;
    logic [31:0] pc_target_e;
`ifdef BRANCH_STATS_EN
    logic [2:0]  stat_tid = '0;
    logic [31:0] stat_branches, stat_taken;
`endif

    always #5 clk = ~clk;

    mt_branch_resolve dut (
        .clk          (clk),
        .rst          (rst),
        .valid_e      (valid_e),
        .tid_e        (tid_e),
        .epoch_e      (epoch_e),
        .br_type_e    (br_type_e),
        .pc_e         (pc_e),
        .imm_e        (imm_e),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .fetch_tid    (fetch_tid),
`ifdef BRANCH_STATS_EN
        .stat_tid     (stat_tid),
        .stat_branches(stat_branches),
        .stat_taken   (stat_taken),
`endif
        .fetch_epoch  (fetch_epoch),
        .kill_e       (kill_e),
        .pc_src_e     (pc_src_e),
        .branch_tid_e (branch_tid_e),
        .pc_target_e  (pc_target_e)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: epoch per thread and the redirect pending for the next edge.
    bit        m_epoch [8];
    bit        m_src;
    bit [2:0]  m_tid;
    bit [31:0] m_tgt;

    typedef struct {
        bit        v;
        bit [2:0]  tid;
        bit        ep;
        bit [3:0]  bt;
        bit [31:0] pc, imm, a, b;
        bit        kill;
        bit        src;
        bit [2:0]  etid;
        bit [31:0] etgt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_taken(bit [3:0] t, bit [31:0] a, bit [31:0] b);
        int sa = int'(a);
        int sb = int'(b);
        case (t)
            4'd1: return a == b;
            4'd2: return a != b;
            4'd3: return sa < sb;
            4'd4: return sa >= sb;
            4'd5: return a < b;
            4'd6: return a >= b;
            4'd7, 4'd8: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [31:0] ref_target(bit [3:0] t, bit [31:0] pc, bit [31:0] imm, bit [31:0] a);
        if (t == 4'd8) return (a + imm) & 32'hFFFF_FFFE;
        return pc + imm;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        valid_e = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        foreach (m_epoch[i]) m_epoch[i] = 1'b0;
        m_src = 1'b0;
        m_tid = '0;
        m_tgt = '0;
    endtask

    task automatic drive_in(bit v, bit [2:0] tid, bit ep, bit [3:0] bt, bit [31:0] pc,
                            bit [31:0] imm, bit [31:0] a, bit [31:0] b, bit [2:0] ftid);
        valid_e = v; tid_e = tid; epoch_e = ep; br_type_e = bt;
        pc_e = pc; imm_e = imm; rs1_e = a; rs2_e = b; fetch_tid = ftid;
        #1;
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic step();
        bit        ek, red;
        bit [31:0] tg;
        ek = valid_e && ((epoch_e != m_epoch[tid_e]) || (m_src && (m_tid == tid_e)));
        chk("kill_e", kill_e, ek);
        chk("fetch_epoch", fetch_epoch, m_epoch[fetch_tid]);
        chk("pc_src_e", pc_src_e, m_src);
        chk("branch_tid_e", branch_tid_e, m_tid);
        chk("pc_target_e", pc_target_e, m_tgt);
        red = valid_e && !ek && ref_taken(br_type_e, rs1_e, rs2_e);
        tg  = ref_target(br_type_e, pc_e, imm_e, rs1_e);
        @(posedge clk);
        if (m_src) m_epoch[m_tid] = ~m_epoch[m_tid];
        m_src = red;
        if (red) begin
            m_tid = tid_e;
            m_tgt = tg;
        end
        #1;
    endtask

    initial begin
        tbl[0]  = '{1, 3, 0, BR_BEQ,  32'h100,      32'h20,       32'd5,        32'd5, 0, 1, 3, 32'h120};
        tbl[1]  = '{1, 0, 0, BR_BLT,  32'h40,       32'h10,       32'hFFFFFFFF, 32'd1, 0, 1, 0, 32'h50};
        tbl[2]  = '{1, 0, 0, BR_BLTU, 32'h40,       32'h10,       32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'h0};
        tbl[3]  = '{1, 5, 0, BR_JALR, 32'h800,      32'h0,        32'h203,      32'd0, 0, 1, 5, 32'h202};
        tbl[4]  = '{1, 2, 0, BR_JAL,  32'hFFFFFFFC, 32'h8,        32'd0,        32'd0, 0, 1, 2, 32'h4};
        tbl[5]  = '{1, 1, 0, BR_BNE,  32'h100,      32'h20,       32'd7,        32'd7, 0, 0, 0, 32'h0};
        tbl[6]  = '{1, 4, 0, BR_BGE,  32'h100,      32'h20,       32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'h0};
        tbl[7]  = '{1, 6, 0, BR_BGEU, 32'h1000,     32'hFFFFFFFC, 32'hFFFFFFFF, 32'd1, 0, 1, 6, 32'hFFC};
        tbl[8]  = '{1, 7, 0, BR_NONE, 32'h100,      32'h20,       32'd5,        32'd5, 0, 0, 0, 32'h0};
        tbl[9]  = '{1, 7, 0, 4'hF,    32'h100,      32'h20,       32'd5,        32'd5, 0, 0, 0, 32'h0};
        tbl[10] = '{1, 3, 1, BR_BEQ,  32'h100,      32'h20,       32'd5,        32'd5, 1, 0, 0, 32'h0};
        tbl[11] = '{0, 3, 0, BR_JAL,  32'h100,      32'h20,       32'd5,        32'd5, 0, 0, 0, 32'h0};

        do_reset();
        chk("reset_pc_src", pc_src_e, 1'b0);
        chk("reset_tid", branch_tid_e, 3'd0);
        chk("reset_target", pc_target_e, 32'h0);

        for (int i = 0; i < 12; i++) begin
            do_reset();
            drive_in(tbl[i].v, tbl[i].tid, tbl[i].ep, tbl[i].bt, tbl[i].pc,
                     tbl[i].imm, tbl[i].a, tbl[i].b, 3'd0);
            chk($sformatf("tbl%0d_kill", i), kill_e, tbl[i].kill);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_src", i), pc_src_e, tbl[i].src);
            chk($sformatf("tbl%0d_tid", i), branch_tid_e, tbl[i].etid);
            chk($sformatf("tbl%0d_tgt", i), pc_target_e, tbl[i].etgt);
        end

        // Redirect on tid 3, then stale and in-window instructions must die.
        do_reset();
        drive_in(1, 3, 0, BR_BEQ, 32'h100, 32'h20, 5, 5, 3);
        step();
        chk("seq1_src", pc_src_e, 1'b1);
        drive_in(1, 3, 0, BR_JAL, 32'h200, 32'h40, 0, 0, 3);
        chk("seq1_window_kill", kill_e, 1'b1);
        step();
        chk("seq1_src_clear", pc_src_e, 1'b0);
        drive_in(1, 3, 0, BR_JAL, 32'h200, 32'h40, 0, 0, 3);
        chk("seq1_epoch3", fetch_epoch, 1'b1);
        chk("seq1_stale_kill", kill_e, 1'b1);
        step();
        chk("seq1_no_redirect", pc_src_e, 1'b0);
        drive_in(1, 4, 0, BR_BEQ, 32'h300, 32'h10, 1, 2, 4);
        chk("seq1_tid4_live", kill_e, 1'b0);
        step();

        // Back-to-back redirects on different threads.
        do_reset();
        drive_in(1, 1, 0, BR_JAL, 32'h10, 32'h100, 0, 0, 1);
        step();
        drive_in(1, 2, 0, BR_JAL, 32'h20, 32'h200, 0, 0, 1);
        step();
        chk("seq2_src2", pc_src_e, 1'b1);
        chk("seq2_tid2", branch_tid_e, 3'd2);
        chk("seq2_tgt2", pc_target_e, 32'h220);
        drive_in(0, 0, 0, BR_NONE, 0, 0, 0, 0, 1);
        chk("seq2_epoch1", fetch_epoch, 1'b1);
        step();
        drive_in(0, 0, 0, BR_NONE, 0, 0, 0, 0, 2);
        chk("seq2_epoch2", fetch_epoch, 1'b1);
        step();

        // Reset with a redirect pending drops it and leaves epochs clear.
        do_reset();
        drive_in(1, 6, 0, BR_JAL, 32'h40, 32'h4, 0, 0, 6);
        step();
        chk("seq3_pending", pc_src_e, 1'b1);
        do_reset();
        drive_in(0, 0, 0, BR_NONE, 0, 0, 0, 0, 6);
        chk("seq3_src_dropped", pc_src_e, 1'b0);
        chk("seq3_epoch6", fetch_epoch, 1'b0);
        chk("seq3_tgt", pc_target_e, 32'h0);
        step();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit [2:0]  t;
            bit [31:0] a, b;
            t = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3)) - 32'd2;
            drive_in($urandom_range(0, 7) != 0, t,
                     ($urandom_range(0, 4) == 0) ? ~m_epoch[t] : m_epoch[t],
                     4'($urandom_range(0, 15)), $urandom, $urandom, a, b,
                     3'($urandom_range(0, 7)));
            step();
        end

`ifdef BRANCH_STATS_EN
        do_reset();
        stat_tid = 3'd0;
        drive_in(1, 0, m_epoch[0], BR_BEQ, 32'h0, 32'h8, 1, 1, 0);
        step();
        drive_in(0, 0, 0, BR_NONE, 0, 0, 0, 0, 0);
        step();
        drive_in(1, 0, m_epoch[0], BR_BNE, 32'h0, 32'h8, 1, 1, 0);
        step();
        drive_in(1, 0, m_epoch[0], BR_JAL, 32'h0, 32'h8, 0, 0, 0);
        step();
        drive_in(0, 0, 0, BR_NONE, 0, 0, 0, 0, 0);
        step();
        drive_in(1, 0, ~m_epoch[0], BR_BEQ, 32'h0, 32'h8, 1, 1, 0);
        step();
        chk("stat_branches", stat_branches, 32'd3);
        chk("stat_taken", stat_taken, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
